// File: rtl/btn_debounce_pkg.sv
// Shared types and helpers for the push-button debounce front end.
package btn_debounce_pkg;

    // Debouncer FSM: idle on a settled level, or qualifying a candidate change.
    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    // Width of a counter that must hold values 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CK,
    input  logic RST,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Plain shift chain, no logic between stages, to give metastability time to resolve.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce_ce.sv
// Button conditioner: synchronizes BTN, debounces it with a consecutive-sample
// counter and produces a clean level D plus a one-cycle accept strobe CE.
// Build option CE_BOTH_EDGES_EN: when defined CE pulses on accepted rises and
// falls; otherwise CE pulses only on accepted rises.
module btn_debounce_ce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic CK,
    input  logic RST,
    input  logic BTN,
    output logic D,
    output logic CE,
    output logic BUSY
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          d_q;
    logic          ce_q;
    logic          busy_q;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CK     (CK),
        .RST    (RST),
        .async_i(BTN),
        .sync_o (s)
    );

    // Debounce FSM with registered D/CE/BUSY; a change is accepted once s has
    // differed from D for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ce_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (s != d_q) begin
                        state_q <= CHECK;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                CHECK: begin
                    if (s == d_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        d_q     <= s;
`ifdef CE_BOTH_EDGES_EN
                        ce_q    <= 1'b1;
`else
                        ce_q    <= s;
`endif
                        state_q <= STABLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign D    = d_q;
    assign CE   = ce_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_btn_debounce_ce.sv
// Bench for btn_debounce_ce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4) with a
// downstream clock-enabled flop driven from D/CE.
module tb_btn_debounce_ce;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DC   = 4;
`ifdef CE_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic CK = 1'b0;
    logic RST;
    logic BTN;
    logic D, CE, BUSY;
    logic q_ff;

    int n_checks = 0;
    int n_errors = 0;

    btn_debounce_ce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .BTN (BTN),
        .D   (D),
        .CE  (CE),
        .BUSY(BUSY)
    );

    always #100 CK = ~CK;

    // Downstream init-value flop that captures D only when strobed.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) q_ff <= 1'b0;
        else if (CE) q_ff <= D;
    end

    // Reference: BTN reaches the debouncer SYNC edges late; a change is
    // accepted after DC consecutive differing samples.
    bit m_d, m_ce, m_busy, m_q;
    int m_run;
    bit sq[$];
    always @(posedge CK or posedge RST) begin
        if (RST) begin
            m_d = 0; m_ce = 0; m_busy = 0; m_q = 0; m_run = 0;
            sq = {};
            repeat (SYNC) sq.push_back(1'b0);
        end else begin
            bit sv;
            sv = sq.pop_front();
            sq.push_back(BTN);
            if (m_ce) m_q = m_d;
            m_ce = 0;
            m_run = (sv != m_d) ? m_run + 1 : 0;
            if (m_run == DC) begin
                m_ce  = BOTH ? 1'b1 : sv;
                m_d   = sv;
                m_run = 0;
            end
            m_busy = (m_run > 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check_eq("model_D", D, m_d);
        check_eq("model_CE", CE, m_ce);
        check_eq("model_BUSY", BUSY, m_busy);
        check_eq("model_Q", q_ff, m_q);
    endtask

    task automatic tick(input logic b);
        @(negedge CK);
        cmp_model();
        BTN = b;
    endtask

    task automatic do_reset();
        @(negedge CK);
        cmp_model();
        RST = 1'b1;
        #1;
        check_eq("rst_D", D, 0);
        check_eq("rst_CE", CE, 0);
        check_eq("rst_BUSY", BUSY, 0);
        @(negedge CK);
        RST = 1'b0;
    endtask

    initial begin
        bit seen_busy;
        RST = 1'b1;
        BTN = 1'b0;
        #1;
        check_eq("init_D", D, 0);
        check_eq("init_CE", CE, 0);
        check_eq("init_BUSY", BUSY, 0);
        check_eq("init_Q", q_ff, 0);
        @(negedge CK);
        @(negedge CK);
        RST = 1'b0;
        repeat (5) tick(1'b0);

        // Clean press
        tick(1'b1);
        for (int e = 1; e <= 8; e++) begin
            @(negedge CK);
            cmp_model();
            check_eq("step_D", D, e >= 6);
            check_eq("step_CE", CE, e == 6);
            check_eq("step_BUSY", BUSY, e >= 3 && e <= 5);
            if (e == 7) check_eq("step_Q", q_ff, 1);
        end

        // Release
        tick(1'b0);
        for (int e = 1; e <= 8; e++) begin
            @(negedge CK);
            cmp_model();
            check_eq("rel_D", D, e < 6);
            check_eq("rel_CE", CE, BOTH && e == 6);
            if (e == 7) check_eq("rel_Q", q_ff, !BOTH);
        end
        repeat (3) tick(1'b0);

        // Short glitch: 3 samples high, then low
        seen_busy = 0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        for (int e = 0; e < 10; e++) begin
            @(negedge CK);
            cmp_model();
            if (BUSY) seen_busy = 1;
            check_eq("glitch_D", D, 0);
            check_eq("glitch_CE", CE, 0);
        end
        check_eq("glitch_BUSY_seen", seen_busy, 1);

        // Bounce: high 2, low 1, high held
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        @(negedge CK);
        check_eq("bounce_CE_pre", CE, 0);
        cmp_model();
        BTN = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge CK);
            cmp_model();
            check_eq("bounce_D", D, e >= 6);
            check_eq("bounce_CE", CE, e == 6);
        end

        // Return to 0 before the reset test
        tick(1'b0);
        repeat (10) tick(1'b0);

        // Reset two samples into qualification
        tick(1'b1);
        repeat (4) begin
            @(negedge CK);
            cmp_model();
        end
        check_eq("mid_BUSY_pre", BUSY, 1);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_D", D, 0);
        check_eq("mid_rst_CE", CE, 0);
        check_eq("mid_rst_BUSY", BUSY, 0);
        @(negedge CK);
        RST = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge CK);
            cmp_model();
            check_eq("mid_D", D, e >= 6);
            check_eq("mid_CE", CE, e == 6);
        end

        // Randomized hold lengths with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic b;
            int unsigned hold;
            b = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 7);
            repeat (hold) tick(b);
            if ($urandom_range(0, 60) == 0) do_reset();
        end
        repeat (12) tick(BTN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
